store_sequencer: RTL



---
 rtl/definitions_pkg.sv | 40 ++++
 rtl/store_lane_align.sv | 59 +++++
 rtl/store_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared types and constants for the store sequencer.
// Optional feature macro: STORE_SPLIT_EN (see store_sequencer.sv).
package definitions_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    SB   = 2'b00,
    SH   = 2'b01,
    SW   = 2'b10,
    RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } store_state_e;

  typedef enum logic [1:0] {
    NONE       = 2'b00,
    MISALIGNED = 2'b01,
    BAD_SIZE   = 2'b10,
    TIMEOUT    = 2'b11
  } store_fault_e;

  // Natural alignment: halfwords on even addresses, words on word boundaries.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    logic result;
    result = 1'b0;
    case (size)
      SH:      result = off[0];
      SW:      result = (off != 2'b00);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for one bus beat of a store.
// beat_sel=0 gives the first (low-address) beat, beat_sel=1 the spill beat.
module store_lane_align
  import definitions_pkg::*;
(
  input  logic [31:0] data,
  input  mem_size_e   size,
  input  logic [1:0]  off,
  input  logic        beat_sel,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        spill
);

  logic [31:0] sized;
  logic [3:0]  base_be;
  logic [2:0]  nbytes;
  logic [2:0]  tail_shift;

  // Truncate the right-justified data to the access size and pick the base enables.
  always_comb begin
    sized   = data;
    base_be = 4'b1111;
    nbytes  = 3'd4;
    case (size)
      SB: begin
        sized   = {24'd0, data[7:0]};
        base_be = 4'b0001;
        nbytes  = 3'd1;
      end
      SH: begin
        sized   = {16'd0, data[15:0]};
        base_be = 4'b0011;
        nbytes  = 3'd2;
      end
      default: begin
        sized   = data;
        base_be = 4'b1111;
        nbytes  = 3'd4;
      end
    endcase
  end

  // The spill beat carries the bytes that did not fit above the offset.
  assign tail_shift = 3'(BYTES_PER_WORD) - {1'b0, off};
  assign spill      = ({1'b0, off} + nbytes) > 3'(BYTES_PER_WORD);

  // Shift enables and data into position for the selected beat.
  always_comb begin
    if (beat_sel) begin
      be    = base_be >> tail_shift;
      wdata = sized >> {tail_shift, 3'b000};
    end else begin
      be    = base_be << off;
      wdata = sized << {off, 3'b000};
    end
  end

endmodule

// File: rtl/store_sequencer.sv
// Store sequencer: turns one store request at a time into one or two
// word-aligned write beats with byte enables, then reports done or fault.
// Optional feature macro: STORE_SPLIT_EN. When defined, unaligned stores are
// legal and word-crossing stores issue a second beat; when undefined, natural
// alignment is required and the second beat path is not built.
module store_sequencer
  import definitions_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic [1:0]        req_size_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [1:0]        fault_cause_o,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  store_state_e state;
  mem_size_e    size_q;
  logic [1:0]   off_q;
  logic [31:0]  data_q;
  logic [CNT_W-1:0] wait_cnt;

  mem_size_e    req_size;
  logic         in_idle;
  logic         misaligned;
  logic         timeout_hit;
  logic         handshake;
  logic [31:0]  align_data;
  mem_size_e    align_size;
  logic [1:0]   align_off;
  logic [31:0]  align_wdata;
  logic [3:0]   align_be;
  logic         align_spill;
  logic [ADDR_W-3:0] next_word;

  assign req_size = mem_size_e'(req_size_i);
  assign in_idle  = (state == IDLE);

  // In IDLE the aligner looks at the incoming request (first beat); once a
  // beat is in flight it looks at the captured request (spill beat).
  assign align_data = in_idle ? req_data_i : data_q;
  assign align_size = in_idle ? req_size : size_q;
  assign align_off  = in_idle ? req_addr_i[1:0] : off_q;

  store_lane_align u_lane_align (
    .data     (align_data),
    .size     (align_size),
    .off      (align_off),
    .beat_sel (!in_idle),
    .wdata    (align_wdata),
    .be       (align_be),
    .spill    (align_spill)
  );

`ifdef STORE_SPLIT_EN
  assign misaligned = 1'b0;
`else
  logic unused_spill;
  assign unused_spill = align_spill;
  assign misaligned   = is_misaligned(req_size, req_addr_i[1:0]);
`endif

  assign handshake   = mem_valid_o && mem_ready_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign next_word   = mem_addr_o[ADDR_W-1:2] + (ADDR_W-2)'(1);

  // Control FSM with all outputs registered; done/fault are single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      req_ready_o   <= 1'b1;
      mem_valid_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_be_o      <= '0;
      done_o        <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= NONE;
      busy_o        <= 1'b0;
      size_q        <= SB;
      off_q         <= '0;
      data_q        <= '0;
      wait_cnt      <= '0;
    end else begin
      done_o        <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= NONE;
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            size_q      <= req_size;
            off_q       <= req_addr_i[1:0];
            data_q      <= req_data_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (req_size == RSVD) begin
              state         <= RESP;
              fault_o       <= 1'b1;
              fault_cause_o <= BAD_SIZE;
            end else if (misaligned) begin
              state         <= RESP;
              fault_o       <= 1'b1;
              fault_cause_o <= MISALIGNED;
            end else begin
              state       <= BEAT0;
              mem_valid_o <= 1'b1;
              mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              mem_wdata_o <= align_wdata;
              mem_be_o    <= align_be;
              wait_cnt    <= '0;
            end
          end
        end
        BEAT0: begin
          if (handshake) begin
`ifdef STORE_SPLIT_EN
            if (align_spill) begin
              state       <= BEAT1;
              mem_addr_o  <= {next_word, 2'b00};
              mem_wdata_o <= align_wdata;
              mem_be_o    <= align_be;
              wait_cnt    <= '0;
            end else begin
              state       <= RESP;
              mem_valid_o <= 1'b0;
              done_o      <= 1'b1;
            end
`else
            state       <= RESP;
            mem_valid_o <= 1'b0;
            done_o      <= 1'b1;
`endif
          end else if (timeout_hit) begin
            state         <= RESP;
            mem_valid_o   <= 1'b0;
            fault_o       <= 1'b1;
            fault_cause_o <= TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
`ifdef STORE_SPLIT_EN
        BEAT1: begin
          if (handshake) begin
            state       <= RESP;
            mem_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else if (timeout_hit) begin
            state         <= RESP;
            mem_valid_o   <= 1'b0;
            fault_o       <= 1'b1;
            fault_cause_o <= TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
`endif
        RESP: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          mem_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
